riscv_mem_responder: RTL

RISCV_MEM_RESPONDER -- requirements
Module: riscv_mem_responder

---
 rtl/riscv_mem_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/riscv_mem_responder.sv
// Word-addressed memory serving an instruction and a data requester, one transaction at a time.
// Define RISCV_MEM_RESP_BYTE_STROBE_EN to honour d_wstrb byte enables on writes.
module riscv_mem_responder #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        busy
);
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned STARVE_MAX = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [31:0]           mem [DEPTH];
    logic [1:0]            state, state_nxt;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
    logic [2:0]            starve_cnt;
    logic                  is_data;
    logic                  is_write;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           wdata;
    logic                  grant_any;
    logic [31:0]           rd_word;
    logic [31:0]           wr_word;

    // Data wins unless the instruction side has been passed over STARVE_MAX times in a row
    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (!reset && state == IDLE) begin
            if (d_req && !(i_req && starve_cnt == 3'(STARVE_MAX))) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    assign grant_any = i_gnt | d_gnt;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    if (LATENCY > 1) begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = CNT_W'(LATENCY) - CNT_W'(2);
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - CNT_W'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Capture the granted request and track consecutive data grants that blocked a fetch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            is_data    <= 1'b0;
            is_write   <= 1'b0;
            idx        <= '0;
            wdata      <= '0;
        end else begin
            if (i_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt) begin
                starve_cnt <= i_req ? starve_cnt + 3'd1 : 3'd0;
            end
            if (grant_any) begin
                is_data  <= d_gnt;
                is_write <= d_gnt & d_we;
                idx      <= d_gnt ? d_addr[DEPTH_LOG2+1:2] : i_addr[DEPTH_LOG2+1:2];
                wdata    <= d_wdata;
            end
        end
    end

    assign rd_word = mem[idx];

`ifdef RISCV_MEM_RESP_BYTE_STROBE_EN
    logic [3:0] wstrb;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wstrb <= '0;
        end else if (grant_any) begin
            wstrb <= d_wstrb;
        end
    end

    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                wr_word[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end
`else
    logic unused_wstrb;
    assign unused_wstrb = ^d_wstrb;
    assign wr_word      = wdata;
`endif

    // Write commits on the edge that leaves RESP; reset clears state first, so no commit
    always_ff @(posedge clock) begin
        if (state == RESP && is_write) begin
            mem[idx] <= wr_word;
        end
    end

    logic unused_addr;
    assign unused_addr = ^{i_addr[31:DEPTH_LOG2+2], i_addr[1:0],
                           d_addr[31:DEPTH_LOG2+2], d_addr[1:0]};

    assign busy     = (state != IDLE);
    assign i_rvalid = (state == RESP) && !is_data;
    assign d_rvalid = (state == RESP) && is_data;
    assign i_rdata  = i_rvalid ? rd_word : '0;
    assign d_rdata  = (d_rvalid && !is_write) ? rd_word : '0;

endmodule
